// File: rtl/scoreboard_pkg.sv
// Shared types and timing constants for the button press interface.
package scoreboard_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP
  } press_state_e;

  localparam int unsigned CLK_HZ             = 100_000_000;
  localparam int unsigned LONG_THRESH_CYCLES = 200_000_000;
  localparam int unsigned CNT_W              = 28;
  localparam int unsigned SHORT_CYCLES_DEF   = 50_000_000;
  localparam int unsigned LONG_CYCLES_DEF    = 250_000_000;
  localparam int unsigned GAP_CYCLES_DEF     = 50_000_000;

  // A zero duration would never reach the expire count, so it is treated as one cycle.
  function automatic int unsigned at_least_one(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

endpackage

// File: rtl/press_pulse_generator_cycle_timer.sv
// Loadable down-counter; expire_o flags the last cycle of a loaded interval.
module cycle_timer #(
  parameter int unsigned W = 28
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expire_o
);

  logic [W-1:0] count_q;

  // Counting holds at 1; the owner reloads or stops on expiry.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q > W'(1))) begin
      count_q <= count_q - W'(1);
    end
  end

  assign expire_o = (count_q == W'(1));

endmodule

// File: rtl/press_pulse_generator.sv
// Turns a short/long press command into a timed button waveform followed by a release gap.
module press_pulse_generator #(
  parameter int unsigned CNT_W        = 28,
  parameter int unsigned SHORT_CYCLES = 50_000_000,
  parameter int unsigned LONG_CYCLES  = 250_000_000,
  parameter int unsigned GAP_CYCLES   = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic cmd_valid_i,
  input  logic cmd_long_i,
  output logic cmd_ready_o,
  input  logic abort_i,
  output logic button_o,
  output logic busy_o,
  output logic done_o,
  output logic aborted_o
);

  import scoreboard_pkg::*;

  localparam logic [CNT_W-1:0] SHORT_LD = CNT_W'(at_least_one(SHORT_CYCLES));
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(at_least_one(LONG_CYCLES));
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(at_least_one(GAP_CYCLES));

  press_state_e     state_q;
  logic             abort_flag_q;
  logic             handshake;
  logic             timer_load;
  logic             timer_en;
  logic             timer_expire;
  logic [CNT_W-1:0] timer_load_val;

  // The command length lives in the timer load; abort wins over natural expiry.
  always_comb begin
    handshake      = (state_q == IDLE) && cmd_valid_i && cmd_ready_o;
    timer_load     = 1'b0;
    timer_load_val = GAP_LD;
    case (state_q)
      IDLE: begin
        timer_load     = handshake;
        timer_load_val = cmd_long_i ? LONG_LD : SHORT_LD;
      end
      PRESS: timer_load = abort_i || timer_expire;
      default: ;
    endcase
    timer_en = (state_q != IDLE);
  end

  cycle_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (timer_load),
    .load_val_i(timer_load_val),
    .en_i      (timer_en),
    .expire_o  (timer_expire)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      abort_flag_q <= 1'b0;
      button_o     <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      aborted_o    <= 1'b0;
      cmd_ready_o  <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      aborted_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (handshake) begin
            state_q      <= PRESS;
            abort_flag_q <= 1'b0;
            button_o     <= 1'b1;
            busy_o       <= 1'b1;
            cmd_ready_o  <= 1'b0;
          end else begin
            cmd_ready_o  <= 1'b1;
          end
        end
        PRESS: begin
          if (abort_i || timer_expire) begin
            state_q  <= GAP;
            button_o <= 1'b0;
            if (abort_i) abort_flag_q <= 1'b1;
          end
        end
        GAP: begin
          if (timer_expire) begin
            state_q     <= IDLE;
            busy_o      <= 1'b0;
            cmd_ready_o <= 1'b1;
            done_o      <= 1'b1;
            aborted_o   <= abort_flag_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
